rr_decode_arbiter: RTL and testbench

- Round-robin arbiter sharing one 4-to-16 active-high decoder select path among 16 requesters.
- Issues a 4-bit grant address plus enable, which drive the decoder's A and E inputs, so exactly one decoder line is high per grant.
- Holds each grant until the owner signals done, drops its request, or the optional hold limit expires.
- Then inserts one idle gap cycle and rotates priority.

---
 rtl/rr_decode_arbiter.sv | 157 +++++++++++++++
 tb/tb_rr_decode_arbiter.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rr_decode_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_decode_arbiter
// Brief    : Round-robin arbiter driving a shared 4-to-16 decoder (A/E inputs)
//            for 16 requesters. Each grant is held until done, request drop
//            or an optional hold limit, followed by one idle gap cycle.
// Options  : define RR_ONEHOT_OUT_EN to add the gated one-hot grant_onehot
//            output (internal decode of grant_addr/grant_en).
// Revision : 1.0 - initial release
// ============================================================================
module rr_decode_arbiter #(
  parameter int MAX_HOLD = 0,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] req,
  input  logic        done,
  output logic [3:0]  grant_addr,
  output logic        grant_en,
  output logic        busy,
  output logic        timeout
`ifdef RR_ONEHOT_OUT_EN
  ,
  output logic [15:0] grant_onehot
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  // Hold-limit compare value; only meaningful when the limit is enabled.
  localparam logic             c_hold_en   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] c_hold_last = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] c_cnt_max   = '1;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [3:0]       r_ptr;
  logic [CNT_W-1:0] r_hold_cnt;

  logic [3:0]       w_win_idx;
  logic             w_found;
  logic             w_req_any;
  logic             w_drop;
  logic             w_hold_hit;
  logic             w_release;

  logic [3:0]       w_addr_nxt;
  logic             w_en_nxt;
  logic             w_busy_nxt;
  logic             w_timeout_nxt;
  logic [3:0]       w_ptr_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_req_any  = |req;
  assign w_drop     = ~req[grant_addr];
  assign w_hold_hit = c_hold_en && (r_hold_cnt == c_hold_last);
  assign w_release  = done || w_drop || w_hold_hit;

  // Priority search: first set request at or above ptr, wrapping 15 -> 0.
  always_comb begin
    w_win_idx = r_ptr;
    w_found   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!w_found && req[r_ptr + 4'(i)]) begin
        w_win_idx = r_ptr + 4'(i);
        w_found   = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: IDLE -> GRANT -> GAP -> IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_req_any) w_state_nxt = S_GRANT;
      S_GRANT: if (w_release) w_state_nxt = S_GAP;
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output/datapath next values; everything below is registered.
  always_comb begin
    w_addr_nxt    = grant_addr;
    w_en_nxt      = 1'b0;
    w_busy_nxt    = 1'b0;
    w_timeout_nxt = 1'b0;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_hold_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_req_any) begin
          w_addr_nxt = w_win_idx;
          w_en_nxt   = 1'b1;
          w_busy_nxt = 1'b1;
          w_cnt_nxt  = '0;
        end
      end
      S_GRANT: begin
        w_busy_nxt = 1'b1;
        if (w_release) begin
          // Releasing owner drops to lowest priority.
          w_ptr_nxt     = grant_addr + 4'd1;
          // Only flag a timeout when the limit alone forced the release.
          w_timeout_nxt = w_hold_hit && !done && !w_drop;
        end else begin
          w_en_nxt  = 1'b1;
          w_cnt_nxt = (r_hold_cnt == c_cnt_max) ? r_hold_cnt : r_hold_cnt + CNT_W'(1);
        end
      end
      default: begin
        // GAP (and unreachable encodings): decoder disabled, head to IDLE.
      end
    endcase
  end

  // Registered outputs, priority pointer and hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_addr <= 4'd0;
      grant_en   <= 1'b0;
      busy       <= 1'b0;
      timeout    <= 1'b0;
      r_ptr      <= 4'd0;
      r_hold_cnt <= '0;
    end else begin
      grant_addr <= w_addr_nxt;
      grant_en   <= w_en_nxt;
      busy       <= w_busy_nxt;
      timeout    <= w_timeout_nxt;
      r_ptr      <= w_ptr_nxt;
      r_hold_cnt <= w_cnt_nxt;
    end
  end

`ifdef RR_ONEHOT_OUT_EN
  // Gated decode of the grant address; all zeros whenever grant_en is low.
  always_comb begin
    grant_onehot = 16'd0;
    if (grant_en) grant_onehot[grant_addr] = 1'b1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_decode_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_decode_arbiter
// Brief    : Self-checking bench for rr_decode_arbiter (MAX_HOLD = 5):
//            table of per-cycle vectors plus reset and rotation sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_decode_arbiter;

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        done;
  logic [3:0]  grant_addr;
  logic        grant_en;
  logic        busy;
  logic        timeout;
`ifdef RR_ONEHOT_OUT_EN
  logic [15:0] grant_onehot;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  rr_decode_arbiter #(.MAX_HOLD(5), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .done       (done),
    .grant_addr (grant_addr),
    .grant_en   (grant_en),
    .busy       (busy),
    .timeout    (timeout)
`ifdef RR_ONEHOT_OUT_EN
    ,
    .grant_onehot (grant_onehot)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] req;
    logic        done;
    logic [3:0]  addr;
    logic        en;
    logic        busy;
    logic        to;
  } vec_t;

  vec_t vecs[40];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [3:0] a, input logic e,
                           input logic b, input logic t);
    logic [15:0] oh;
    chk({tag, ".grant_addr"}, 32'(grant_addr), 32'(a));
    chk({tag, ".grant_en"},   32'(grant_en),   32'(e));
    chk({tag, ".busy"},       32'(busy),       32'(b));
    chk({tag, ".timeout"},    32'(timeout),    32'(t));
    oh = 16'd0;
    if (e) oh[a] = 1'b1;
`ifdef RR_ONEHOT_OUT_EN
    chk({tag, ".grant_onehot"}, 32'(grant_onehot), 32'(oh));
`endif
  endtask

  // Drive inputs mid-cycle, then sample just after the next rising edge.
  task automatic step(input logic [15:0] r, input logic d);
    @(negedge clk);
    req  = r;
    done = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // req, done, expected addr, en, busy, timeout (after the edge)
    vecs[0]  = '{16'h0010, 1'b0, 4'd4,  1'b1, 1'b1, 1'b0};
    vecs[1]  = '{16'h0010, 1'b1, 4'd4,  1'b0, 1'b1, 1'b0};
    vecs[2]  = '{16'h0010, 1'b0, 4'd4,  1'b0, 1'b0, 1'b0};
    vecs[3]  = '{16'h0010, 1'b0, 4'd4,  1'b1, 1'b1, 1'b0};
    vecs[4]  = '{16'h0010, 1'b1, 4'd4,  1'b0, 1'b1, 1'b0};
    vecs[5]  = '{16'h4005, 1'b0, 4'd4,  1'b0, 1'b0, 1'b0};
    vecs[6]  = '{16'h4005, 1'b0, 4'd14, 1'b1, 1'b1, 1'b0};
    vecs[7]  = '{16'h4005, 1'b1, 4'd14, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{16'h4005, 1'b0, 4'd14, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{16'h4005, 1'b0, 4'd0,  1'b1, 1'b1, 1'b0};
    vecs[10] = '{16'h4005, 1'b1, 4'd0,  1'b0, 1'b1, 1'b0};
    vecs[11] = '{16'h4005, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0};
    vecs[12] = '{16'h4005, 1'b0, 4'd2,  1'b1, 1'b1, 1'b0};
    vecs[13] = '{16'h4005, 1'b1, 4'd2,  1'b0, 1'b1, 1'b0};
    vecs[14] = '{16'h4005, 1'b0, 4'd2,  1'b0, 1'b0, 1'b0};
    vecs[15] = '{16'h4005, 1'b0, 4'd14, 1'b1, 1'b1, 1'b0};
    vecs[16] = '{16'h4005, 1'b1, 4'd14, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{16'h0080, 1'b0, 4'd14, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{16'h0080, 1'b0, 4'd7,  1'b1, 1'b1, 1'b0};
    vecs[19] = '{16'h0000, 1'b0, 4'd7,  1'b0, 1'b1, 1'b0};
    vecs[20] = '{16'h0180, 1'b0, 4'd7,  1'b0, 1'b0, 1'b0};
    vecs[21] = '{16'h0180, 1'b0, 4'd8,  1'b1, 1'b1, 1'b0};
    vecs[22] = '{16'h0180, 1'b1, 4'd8,  1'b0, 1'b1, 1'b0};
    vecs[23] = '{16'h0000, 1'b0, 4'd8,  1'b0, 1'b0, 1'b0};
    vecs[24] = '{16'h0000, 1'b0, 4'd8,  1'b0, 1'b0, 1'b0};
    vecs[25] = '{16'h0000, 1'b1, 4'd8,  1'b0, 1'b0, 1'b0};
    vecs[26] = '{16'h0002, 1'b0, 4'd1,  1'b1, 1'b1, 1'b0};
    vecs[27] = '{16'h0002, 1'b0, 4'd1,  1'b1, 1'b1, 1'b0};
    vecs[28] = '{16'h0002, 1'b0, 4'd1,  1'b1, 1'b1, 1'b0};
    vecs[29] = '{16'h0002, 1'b0, 4'd1,  1'b1, 1'b1, 1'b0};
    vecs[30] = '{16'h0002, 1'b0, 4'd1,  1'b1, 1'b1, 1'b0};
    vecs[31] = '{16'h0002, 1'b0, 4'd1,  1'b0, 1'b1, 1'b1};
    vecs[32] = '{16'h0002, 1'b0, 4'd1,  1'b0, 1'b0, 1'b0};
    vecs[33] = '{16'h0002, 1'b0, 4'd1,  1'b1, 1'b1, 1'b0};
    vecs[34] = '{16'h0002, 1'b0, 4'd1,  1'b1, 1'b1, 1'b0};
    vecs[35] = '{16'h0002, 1'b0, 4'd1,  1'b1, 1'b1, 1'b0};
    vecs[36] = '{16'h0002, 1'b0, 4'd1,  1'b1, 1'b1, 1'b0};
    vecs[37] = '{16'h0002, 1'b0, 4'd1,  1'b1, 1'b1, 1'b0};
    vecs[38] = '{16'h0002, 1'b1, 4'd1,  1'b0, 1'b1, 1'b0};
    vecs[39] = '{16'h0000, 1'b0, 4'd1,  1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    req   = 16'd0;
    done  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_out("reset", 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 40; i++) begin
      step(vecs[i].req, vecs[i].done);
      check_out($sformatf("vec%0d", i), vecs[i].addr, vecs[i].en, vecs[i].busy, vecs[i].to);
    end

    // Asynchronous reset in the middle of a grant.
    step(16'hFFFF, 1'b0);
    check_out("pre_rst_grant", 4'd2, 1'b1, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_rst", 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    // Pointer back at 0: bit 0 wins over bit 15.
    step(16'h8001, 1'b0);
    check_out("post_rst_grant", 4'd0, 1'b1, 1'b1, 1'b0);

    // Full rotation with all requesting, done on every grant.
    for (int k = 1; k <= 16; k++) begin
      step(16'hFFFF, 1'b1);
      check_out($sformatf("rot%0d_gap", k), 4'((k + 15) % 16), 1'b0, 1'b1, 1'b0);
      step(16'hFFFF, 1'b0);
      check_out($sformatf("rot%0d_idle", k), 4'((k + 15) % 16), 1'b0, 1'b0, 1'b0);
      step(16'hFFFF, 1'b0);
      check_out($sformatf("rot%0d_grant", k), 4'(k % 16), 1'b1, 1'b1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
